// File: rtl/cmp4_sort_ctrl_pkg.sv
// Shared definitions for the cmp4 sorting controller: data width,
// FSM state encoding and comparator result bit positions.
package cmp4_sort_pkg;

  localparam int DATA_W = 4;

  // Bit positions inside the 3-bit comparator result vector
  localparam int LT = 2;
  localparam int GT = 1;
  localparam int EQ = 0;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/cmp4_sort_ctrl_cmp.sv
// Gate-level 4-bit unsigned magnitude comparator. This is the only
// comparison resource in the controller; result is {lt, gt, eq}.
module Comparator_4bits
  import cmp4_sort_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [2:0]        result
);

  logic [3:0] eq_bit;
  logic [3:0] gt_bit;
  logic [3:0] lt_bit;

  // Per-bit equality and strict inequality terms
  assign eq_bit = ~(a ^ b);
  assign gt_bit = a & ~b;
  assign lt_bit = ~a & b;

  // MSB-first priority: a lower bit only decides when all higher bits match
  assign result[GT] = gt_bit[3]
                    | (eq_bit[3] & gt_bit[2])
                    | (eq_bit[3] & eq_bit[2] & gt_bit[1])
                    | (eq_bit[3] & eq_bit[2] & eq_bit[1] & gt_bit[0]);

  assign result[LT] = lt_bit[3]
                    | (eq_bit[3] & lt_bit[2])
                    | (eq_bit[3] & eq_bit[2] & lt_bit[1])
                    | (eq_bit[3] & eq_bit[2] & eq_bit[1] & lt_bit[0]);

  assign result[EQ] = eq_bit[3] & eq_bit[2] & eq_bit[1] & eq_bit[0];

endmodule

// File: rtl/cmp4_sort_ctrl.sv
// Frame sorting controller: loads DEPTH 4-bit values, bubble-sorts them
// in place with one shared comparator (one compare per clock, early exit
// on a swap-free pass), then streams the sorted frame out.
module cmp4_sort_ctrl
  import cmp4_sort_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_PASS = PTR_W'(DEPTH - 2);

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  pass_idx;
  logic [PTR_W-1:0]  cmp_idx;
  logic [PTR_W-1:0]  cmp_idx_next;
  logic [PTR_W-1:0]  pass_last_idx;
  logic              swap_flag;

  logic [DATA_W-1:0] cmp_a;
  logic [DATA_W-1:0] cmp_b;
  logic [2:0]        cmp_result;

  logic load_fire;
  logic load_last;
  logic drain_fire;
  logic drain_last;
  logic do_swap;
  logic sort_at_last;
  logic sort_done;

  // Operand muxes: adjacent pair under the compare index
  assign cmp_idx_next  = cmp_idx + PTR_W'(1);
  assign cmp_a         = mem[cmp_idx];
  assign cmp_b         = mem[cmp_idx_next];
  assign pass_last_idx = LAST_PASS - pass_idx;

  Comparator_4bits u_cmp (
    .a      (cmp_a),
    .b      (cmp_b),
    .result (cmp_result)
  );

  // Swap only on a strict greater-than, so equal keys keep their order
  assign do_swap      = (state_q == SORT) & cmp_result[GT] & ~cmp_result[EQ] & ~cmp_result[LT];
  assign sort_at_last = (state_q == SORT) && (cmp_idx == pass_last_idx);
  assign sort_done    = sort_at_last && (!(swap_flag || do_swap) || (pass_idx == LAST_PASS));

  assign load_fire  = (state_q == LOAD) && in_valid;
  assign load_last  = load_fire && (wr_ptr == LAST_PTR);
  assign drain_fire = (state_q == DRAIN) && out_ready;
  assign drain_last = drain_fire && (rd_ptr == LAST_PTR);

  // Outputs decode directly from state and the registered memory
  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == SORT);
  assign out_data  = (state_q == DRAIN) ? mem[rd_ptr] : '0;
  assign out_last  = (state_q == DRAIN) && (rd_ptr == LAST_PTR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_last)  state_d = SORT;
      SORT:    if (sort_done)  state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Frame memory: written by the loader, rearranged by swaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (load_fire) begin
      mem[wr_ptr] <= in_data;
    end else if (do_swap) begin
      mem[cmp_idx]      <= cmp_b;
      mem[cmp_idx_next] <= cmp_a;
    end
  end

  // Load/drain pointers and the bubble-sort schedule counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pass_idx  <= '0;
      cmp_idx   <= '0;
      swap_flag <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (load_last) begin
            wr_ptr    <= '0;
            pass_idx  <= '0;
            cmp_idx   <= '0;
            swap_flag <= 1'b0;
          end else if (load_fire) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
        end
        SORT: begin
          if (sort_at_last) begin
            if (!sort_done) begin
              pass_idx  <= pass_idx + PTR_W'(1);
              cmp_idx   <= '0;
              swap_flag <= 1'b0;
            end
          end else begin
            cmp_idx   <= cmp_idx_next;
            swap_flag <= swap_flag | do_swap;
          end
        end
        DRAIN: begin
          if (drain_last) begin
            rd_ptr <= '0;
          end else if (drain_fire) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp4_sort_ctrl.sv
// Directed testbench for cmp4_sort_ctrl with DEPTH = 8.
module tb_cmp4_sort_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;

  int n_checks;
  int n_fail;

  cmp4_sort_ctrl #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack eight values, element 0 in the low nibble
  function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {4'(a7), 4'(a6), 4'(a5), 4'(a4), 4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  // Drive one frame, one value per cycle; returns at the negedge after the last accept
  task automatic load_frame(input logic [31:0] frame);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = frame[4*k +: 4];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 4'd0;
  endtask

  // Count cycles with busy high, bounded
  task automatic wait_sort(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // Collect the drained frame, optionally stalling 1-5 cycles before each element
  task automatic drain_capture(input bit stall, output logic [31:0] data, output logic [7:0] lasts,
                               output bit held_ok, output bit inready_ok, output int n);
    int guard;
    logic [3:0] hd;
    logic hl;
    data = '0; lasts = '0; held_ok = 1'b1; inready_ok = 1'b1; n = 0; guard = 0;
    while (n < 8 && guard < 400) begin
      if (stall) begin
        int st;
        st = $urandom_range(1, 5);
        out_ready = 1'b0;
        hd = out_data;
        hl = out_last;
        for (int s = 0; s < st; s++) begin
          @(negedge clk);
          guard++;
          if (out_data !== hd || out_last !== hl) held_ok = 1'b0;
        end
      end
      out_ready = 1'b1;
      if (in_ready !== 1'b0) inready_ok = 1'b0;
      if (out_valid === 1'b1) begin
        data[4*n +: 4] = out_data;
        lasts[n] = out_last;
        n++;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({in_ready, out_valid, out_data, out_last, busy} !== 8'b1_0_0000_0_0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {in_ready, out_valid, out_data, out_last, busy}, 8'b1_0_0000_0_0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [7:0] l; bit h, r; int n, cyc;
    load_frame(pk(8, 5, 15, 0, 5, 2, 9, 1));
    wait_sort(cyc);
    drain_capture(1'b0, d, l, h, r, n);
    n_checks++;
    if (n !== 8 || d !== pk(0, 1, 2, 5, 5, 8, 9, 15)) begin
      n_fail++;
      $display("[TB] FAIL basic_data: got %h (n=%0d) expected %h", d, n, pk(0, 1, 2, 5, 5, 8, 9, 15));
    end
    n_checks++;
    if (l !== 8'h80) begin
      n_fail++;
      $display("[TB] FAIL basic_last: got %b expected %b", l, 8'h80);
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_return_load: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_sorted();
    logic [31:0] d; logic [7:0] l; bit h, r; int n, cyc;
    load_frame(pk(0, 1, 2, 3, 4, 5, 6, 7));
    wait_sort(cyc);
    n_checks++;
    if (cyc !== 7) begin
      n_fail++;
      $display("[TB] FAIL sorted_busy_cycles: got %0d expected 7", cyc);
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sorted_out_valid_rise: got %b expected 1", out_valid);
    end
    drain_capture(1'b0, d, l, h, r, n);
    n_checks++;
    if (d !== pk(0, 1, 2, 3, 4, 5, 6, 7)) begin
      n_fail++;
      $display("[TB] FAIL sorted_data: got %h expected %h", d, pk(0, 1, 2, 3, 4, 5, 6, 7));
    end
  endtask

  task automatic test_reverse();
    logic [31:0] d; logic [7:0] l; bit h, r; int n, cyc;
    load_frame(pk(15, 14, 13, 12, 11, 10, 9, 8));
    wait_sort(cyc);
    n_checks++;
    if (cyc !== 28) begin
      n_fail++;
      $display("[TB] FAIL reverse_busy_cycles: got %0d expected 28", cyc);
    end
    drain_capture(1'b0, d, l, h, r, n);
    n_checks++;
    if (d !== pk(8, 9, 10, 11, 12, 13, 14, 15)) begin
      n_fail++;
      $display("[TB] FAIL reverse_data: got %h expected %h", d, pk(8, 9, 10, 11, 12, 13, 14, 15));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [7:0] l; bit h, r; int n, cyc;
    load_frame(pk(4, 12, 7, 1, 9, 3, 14, 6));
    wait_sort(cyc);
    drain_capture(1'b1, d, l, h, r, n);
    n_checks++;
    if (n !== 8 || d !== pk(1, 3, 4, 6, 7, 9, 12, 14)) begin
      n_fail++;
      $display("[TB] FAIL bp_data: got %h (n=%0d) expected %h", d, n, pk(1, 3, 4, 6, 7, 9, 12, 14));
    end
    n_checks++;
    if (h !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_hold: got stable=%b expected 1", h);
    end
    n_checks++;
    if (r !== 1'b1 || l !== 8'h80) begin
      n_fail++;
      $display("[TB] FAIL bp_in_ready_last: in_ready_low=%b lasts=%b expected 1/%b", r, l, 8'h80);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_in_ready_rise: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_wrong_state();
    logic [31:0] d; logic [7:0] l; bit h, r; int n, cyc;
    load_frame(pk(10, 2, 6, 2, 13, 0, 11, 5));
    in_valid = 1'b1;
    in_data  = 4'd7;
    wait_sort(cyc);
    drain_capture(1'b0, d, l, h, r, n);
    in_valid = 1'b0;
    in_data  = 4'd0;
    n_checks++;
    if (d !== pk(0, 2, 2, 5, 6, 10, 11, 13)) begin
      n_fail++;
      $display("[TB] FAIL ws_data: got %h expected %h", d, pk(0, 2, 2, 5, 6, 10, 11, 13));
    end
    load_frame(pk(15, 0, 14, 1, 13, 2, 12, 3));
    wait_sort(cyc);
    drain_capture(1'b0, d, l, h, r, n);
    n_checks++;
    if (d !== pk(0, 1, 2, 3, 12, 13, 14, 15)) begin
      n_fail++;
      $display("[TB] FAIL ws_next_frame: got %h expected %h", d, pk(0, 1, 2, 3, 12, 13, 14, 15));
    end
  endtask

  task automatic test_reset_mid_sort();
    logic [31:0] d; logic [7:0] l; bit h, r; int n, cyc;
    load_frame(pk(9, 8, 7, 6, 5, 4, 3, 2));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_data, out_last, busy} !== 8'b1_0_0000_0_0) begin
      n_fail++;
      $display("[TB] FAIL mid_sort_reset: got %b expected %b",
               {in_ready, out_valid, out_data, out_last, busy}, 8'b1_0_0000_0_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_sort_release: out_valid=%b busy=%b in_ready=%b expected 0/0/1",
               out_valid, busy, in_ready);
    end
    load_frame(pk(3, 3, 1, 1, 0, 0, 2, 2));
    wait_sort(cyc);
    drain_capture(1'b0, d, l, h, r, n);
    n_checks++;
    if (n !== 8 || d !== pk(0, 0, 1, 1, 2, 2, 3, 3)) begin
      n_fail++;
      $display("[TB] FAIL mid_sort_next_frame: got %h (n=%0d) expected %h", d, n, pk(0, 0, 1, 1, 2, 2, 3, 3));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_sorted();
    test_reverse();
    test_backpressure();
    test_wrong_state();
    test_reset_mid_sort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
